// File: rtl/rvmem_req_bridge.sv
// rvmem_req_bridge: one RV32I load/store at a time onto split wa/wd/wb write and ra/rd read handshakes; core req/resp on one side, write and read channels on the other
module rvmem_req_bridge #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MASK_WIDTH = MEM_DATA_WIDTH / 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_fcn,
  input  logic [2:0]                req_typ,
  input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [MEM_DATA_WIDTH-1:0] req_data,
  output logic                      resp_valid,
  output logic                      resp_err,
  output logic [MEM_DATA_WIDTH-1:0] resp_data,
  output logic                      waen,
  output logic                      wden,
  output logic [MEM_ADDR_WIDTH-1:0] waddr,
  output logic [MEM_DATA_WIDTH-1:0] wdata,
  output logic [MASK_WIDTH-1:0]     wmask,
  input  logic                      wardy,
  input  logic                      wdrdy,
  input  logic                      wbvld,
  output logic                      raen,
  output logic                      rden,
  output logic [MEM_ADDR_WIDTH-1:0] raddr,
  input  logic [MEM_DATA_WIDTH-1:0] rdata,
  input  logic                      rardy,
  input  logic                      rdrdy
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;
  state_t state, state_n;
  logic fcn_q, err_q, bad, accept, acc_wr, acc_rd;
  logic [2:0] typ_q;
  logic [1:0] off_q;
  logic [15:0] w;
  logic [MEM_ADDR_WIDTH-1:0] word_addr;
  logic [MEM_DATA_WIDTH-1:0] rword, st_data, ld_data;
  logic [MASK_WIDTH-1:0] st_mask;
  assign bad = req_typ[1:0] == 2'd3 || req_typ == 3'd6 ||
               (req_typ[1:0] == 2'd1 && req_addr[0]) ||
               (req_typ[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
  assign accept = state == IDLE && req_valid && req_ready;
  assign acc_wr = accept && !bad && req_fcn;
  assign acc_rd = accept && !bad && !req_fcn;
  assign word_addr = {req_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
  assign st_data = req_typ[1:0] == 2'd0 ? {4{req_data[7:0]}} :
                   req_typ[1:0] == 2'd1 ? {2{req_data[15:0]}} : req_data;
  assign st_mask = req_typ[1:0] == 2'd0 ? 4'b0001 << req_addr[1:0] :
                   req_typ[1:0] == 2'd1 ? 4'b0011 << req_addr[1:0] : 4'hF;
  assign w = 16'(rword >> {off_q, 3'b000});
  assign ld_data = typ_q[1:0] == 2'd0 ? {{24{~typ_q[2] & w[7]}}, w[7:0]} :
                   typ_q[1:0] == 2'd1 ? {{16{~typ_q[2] & w[15]}}, w} : rword;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = bad ? RESP : req_fcn ? WR_REQ : RD_REQ;
      WR_REQ:  if ((!waen || wardy) && (!wden || wdrdy)) state_n = WR_RESP;
      WR_RESP: if (wbvld) state_n = RESP;
      RD_REQ:  if (rardy) state_n = RD_DATA;
      RD_DATA: if (rdrdy) state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  // resp_valid follows the RESP state by one cycle, and req_ready stays low through that
  // response cycle so a new request is never accepted alongside the response pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_data <= '0;
      waen <= 1'b0;
      wden <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      wmask <= '0;
      raen <= 1'b0;
      rden <= 1'b0;
      raddr <= '0;
      fcn_q <= 1'b0;
      err_q <= 1'b0;
      typ_q <= '0;
      off_q <= '0;
      rword <= '0;
    end else begin
      state <= state_n;
      req_ready <= state_n == IDLE && state != RESP;
      waen <= acc_wr || (waen && !wardy);
      wden <= acc_wr || (wden && !wdrdy);
      raen <= acc_rd || (raen && !rardy);
      rden <= (state == RD_REQ && rardy) || (rden && !rdrdy);
      resp_valid <= state == RESP;
      resp_err <= state == RESP && err_q;
      resp_data <= state == RESP && !err_q && !fcn_q ? ld_data : '0;
      if (accept) begin
        fcn_q <= req_fcn;
        err_q <= bad;
        typ_q <= req_typ;
        off_q <= req_addr[1:0];
      end
      if (acc_wr) begin
        waddr <= word_addr;
        wdata <= st_data;
        wmask <= st_mask;
      end
      if (acc_rd) raddr <= word_addr;
      if (state == RD_DATA && rdrdy) rword <= rdata;
    end
  end
endmodule
